sipo_deserializer: RTL and testbench

//  Receive end of the shift-register datapath: collects a serial bit stream into WIDTH-bit

---
 rtl/sipo_pkg.sv | 16 +
 rtl/sipo_shift_core.sv | 82 ++++++++
 rtl/sipo_deserializer.sv | 106 ++++++++++
 tb/tb_sipo_deserializer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Holds the default word width, holding-FSM states and counter-width helper.
package sipo_pkg;

  localparam int SIPO_WIDTH_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } sipo_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and direction latch for the deserializer.
// Ports: clk, rst_n, sin/sin_valid/sin_start/msb_first in; bit_cnt,
//        word_done (one-cycle, combinational with the last bit), word_data out.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             msb_first,
  output logic [CW-1:0]    bit_cnt,
  output logic             word_done,
  output logic [WIDTH-1:0] word_data
);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic             at_first;
  logic             at_last;
  logic             dir_eff;
  logic [WIDTH-1:0] shifted;

  // A bit that opens a word (count 0 or explicit start) takes the
  // current msb_first; later bits keep the latched direction.
  assign at_first = (cnt_q == '0) || sin_start;
  assign at_last  = (cnt_q == CW'(WIDTH - 1));
  assign dir_eff  = at_first ? msb_first : dir_q;

  always_comb begin
    shifted = '0;
    if (dir_eff) begin
      shifted = {sh_q[WIDTH-2:0], sin};
    end else begin
      shifted = {sin, sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (sin_valid) begin
      sh_d  = shifted;
      dir_d = dir_eff;
      if (sin_start) begin
        cnt_d = CW'(1);
      end else if (at_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (sin_start) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Stale bits left by a restarted word are fully shifted out before
  // the next completion, so no explicit clear is needed on start.
  assign word_done = sin_valid && !sin_start && at_last;
  assign word_data = shifted;
  assign bit_cnt   = cnt_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer with a one-entry valid/ready holding register.
// Ports: clk, rst_n, sin, sin_valid, sin_start, msb_first, par_ready, overrun_clr in;
//        par_out, par_valid, bit_cnt, overrun (sticky drop flag) out.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter  int WIDTH = SIPO_WIDTH_DEF,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  input  logic             msb_first,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun,
  input  logic             overrun_clr
);

  logic             word_done;
  logic [WIDTH-1:0] word_data;

  sipo_shift_core #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sin_start (sin_start),
    .msb_first (msb_first),
    .bit_cnt   (bit_cnt),
    .word_done (word_done),
    .word_data (word_data)
  );

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  always_comb begin
    state_d     = state_q;
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    drop        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (word_done) begin
          par_out_d   = word_data;
          par_valid_d = 1'b1;
          state_d     = HELD;
        end
      end
      HELD: begin
        if (word_done && par_ready) begin
          // Consumer takes the old word as the new one lands.
          par_out_d = word_data;
        end else if (word_done) begin
          drop = 1'b1;
        end else if (par_ready) begin
          par_valid_d = 1'b0;
          state_d     = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench for sipo_deserializer (WIDTH=8).
// Stimulus pushes expected words; a negedge monitor pops them on handshakes.
module tb_sipo_deserializer;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sin_start;
  logic       msb_first;
  logic [7:0] par_out;
  logic       par_valid;
  logic       par_ready;
  logic [2:0] bit_cnt;
  logic       overrun;
  logic       overrun_clr;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  sipo_deserializer #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .msb_first   (msb_first),
    .par_out     (par_out),
    .par_valid   (par_valid),
    .par_ready   (par_ready),
    .bit_cnt     (bit_cnt),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && par_valid && par_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", par_out);
      end else begin
        chk("sb_word", {24'd0, par_out}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one word; bit order from msb; start on bit 0.
  // tog flips msb_first after bit 3; ready_at raises par_ready at that bit.
  task automatic send_word(input logic [7:0] w, input logic msb,
                           input logic tog, input int ready_at);
    msb_first = msb;
    for (int i = 0; i < 8; i++) begin
      if (tog && i == 4) msb_first = ~msb;
      if (i == ready_at) par_ready = 1'b1;
      sin       = msb ? w[7-i] : w[i];
      sin_valid = 1'b1;
      sin_start = (i == 0);
      @(posedge clk);
      #1;
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  initial begin
    logic [7:0] a5;
    rst_n       = 1'b0;
    sin         = 1'b0;
    sin_valid   = 1'b0;
    sin_start   = 1'b0;
    msb_first   = 1'b1;
    par_ready   = 1'b0;
    overrun_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_par_valid", par_valid, 0);
    chk("rst_par_out", par_out, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    idle(1);

    // 1: MSB-first 0,0,1,1,1,0,1,0 -> 3A
    par_ready = 1'b1;
    sb.push_back(8'h3A);
    send_word(8'h3A, 1'b1, 1'b0, -1);
    chk("t1_valid", par_valid, 1);
    chk("t1_out", par_out, 8'h3A);
    chk("t1_cnt", bit_cnt, 0);
    idle(1);
    chk("t1_valid_drop", par_valid, 0);

    // 2: same bit sequence LSB-first -> 5C; toggled msb_first ignored
    sb.push_back(8'h5C);
    send_word(8'h5C, 1'b0, 1'b0, -1);
    chk("t2_out", par_out, 8'h5C);
    idle(1);
    sb.push_back(8'h5C);
    send_word(8'h5C, 1'b0, 1'b1, -1);
    chk("t2_tog_out", par_out, 8'h5C);
    idle(1);

    // 3: no ready; 3A then FF back to back -> FF dropped
    par_ready = 1'b0;
    send_word(8'h3A, 1'b1, 1'b0, -1);
    chk("t3_held", par_out, 8'h3A);
    send_word(8'hFF, 1'b1, 1'b0, -1);
    chk("t3_keep", par_out, 8'h3A);
    chk("t3_overrun", overrun, 1);
    chk("t3_valid", par_valid, 1);
    sb.push_back(8'h3A);
    par_ready = 1'b1;
    idle(1);
    chk("t3_drain", par_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    chk("t3_clr", overrun, 0);

    // 4: four words streamed with no gaps, ready high
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    sb.push_back(8'hC3);
    sb.push_back(8'h7E);
    send_word(8'h12, 1'b1, 1'b0, -1);
    send_word(8'h34, 1'b0, 1'b0, -1);
    send_word(8'hC3, 1'b1, 1'b0, -1);
    send_word(8'h7E, 1'b0, 1'b0, -1);
    idle(2);
    chk("t4_overrun", overrun, 0);
    chk("t4_sb_empty", sb.size(), 0);

    // 4b: completion while held with ready -> reload, no bubble
    par_ready = 1'b0;
    sb.push_back(8'h3C);
    send_word(8'h3C, 1'b1, 1'b0, -1);
    sb.push_back(8'h81);
    send_word(8'h81, 1'b1, 1'b0, 7);
    chk("t4b_reload_valid", par_valid, 1);
    chk("t4b_reload_out", par_out, 8'h81);
    idle(1);
    chk("t4b_overrun", overrun, 0);
    chk("t4b_empty", par_valid, 0);

    // 5: 3 junk bits, then restart with A5
    msb_first = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sin       = 1'b1;
      sin_valid = 1'b1;
      sin_start = (i == 0);
      @(posedge clk);
      #1;
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
    chk("t5_cnt3", bit_cnt, 3);
    chk("t5_no_partial", par_valid, 0);
    sb.push_back(8'hA5);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sin       = a5[7-i];
      sin_valid = 1'b1;
      sin_start = (i == 0);
      @(posedge clk);
      #1;
      if (i == 0) chk("t5_cnt_restart", bit_cnt, 1);
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
    chk("t5_out", par_out, 8'hA5);
    idle(1);

    // 6: async reset mid-word while holding and with overrun set
    par_ready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, -1);
    send_word(8'h22, 1'b1, 1'b0, -1);
    chk("t6_pre_overrun", overrun, 1);
    msb_first = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sin       = 1'b1;
      sin_valid = 1'b1;
      sin_start = (i == 0);
      @(posedge clk);
      #1;
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
    chk("t6_pre_cnt", bit_cnt, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", par_valid, 0);
    chk("t6_cnt", bit_cnt, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_out", par_out, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    par_ready = 1'b1;
    idle(1);
    sb.push_back(8'h96);
    send_word(8'h96, 1'b1, 1'b0, -1);
    chk("t6_after_out", par_out, 8'h96);
    idle(3);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
